// File: rtl/axilite_arb_pkg.sv
// Shared types and constants for the N:1 AXI-Lite arbiter.
// Also provides the index-width helper used by the arbiter and its sub-blocks.
package axilite_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axilite_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// Kept generic so other shared-resource blocks can reuse it.
module rr_arbiter
    import axilite_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    int unsigned idx;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/axilite_arbiter.sv
// N:1 AXI-Lite arbiter: one whole write or read transaction at a time, round-robin,
// grant held from arbitration until the response handshake.
module axilite_arbiter
    import axilite_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int STRB_W    = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [N_MASTERS*ADDR_W-1:0]   s_awaddr,
    input  logic [N_MASTERS*3-1:0]        s_awprot,
    input  logic [N_MASTERS-1:0]          s_awvalid,
    output logic [N_MASTERS-1:0]          s_awready,
    input  logic [N_MASTERS*DATA_W-1:0]   s_wdata,
    input  logic [N_MASTERS*STRB_W-1:0]   s_wstrb,
    input  logic [N_MASTERS-1:0]          s_wvalid,
    output logic [N_MASTERS-1:0]          s_wready,
    output logic [N_MASTERS*2-1:0]        s_bresp,
    output logic [N_MASTERS-1:0]          s_bvalid,
    input  logic [N_MASTERS-1:0]          s_bready,
    input  logic [N_MASTERS*ADDR_W-1:0]   s_araddr,
    input  logic [N_MASTERS*3-1:0]        s_arprot,
    input  logic [N_MASTERS-1:0]          s_arvalid,
    output logic [N_MASTERS-1:0]          s_arready,
    output logic [N_MASTERS*DATA_W-1:0]   s_rdata,
    output logic [N_MASTERS*2-1:0]        s_rresp,
    output logic [N_MASTERS-1:0]          s_rvalid,
    input  logic [N_MASTERS-1:0]          s_rready,

    output logic [ADDR_W-1:0]             m_awaddr,
    output logic [2:0]                    m_awprot,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [DATA_W-1:0]             m_wdata,
    output logic [STRB_W-1:0]             m_wstrb,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    output logic [ADDR_W-1:0]             m_araddr,
    output logic [2:0]                    m_arprot,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rvalid,
    output logic                          m_rready
);

    localparam int IW = idx_w(N_MASTERS);

    state_t          state;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   ptr_next;
    logic            aw_done;
    logic            w_done;

    logic [N_MASTERS-1:0] req;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_any;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign req = s_awvalid | s_arvalid;

    rr_arbiter #(
        .N (N_MASTERS)
    ) u_rr (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign aw_hs    = m_awvalid & m_awready;
    assign w_hs     = m_wvalid  & m_wready;
    assign b_hs     = m_bvalid  & m_bready;
    assign ar_hs    = m_arvalid & m_arready;
    assign r_hs     = m_rvalid  & m_rready;
    assign ptr_next = (grant == IW'(N_MASTERS - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A master presenting both AW and AR is served write-first.
                    if (gnt_any) begin
                        grant <= gnt_idx;
                        state <= s_awvalid[gnt_idx] ? WR : RD;
                    end
                end
                WR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done | aw_hs) && (w_done | w_hs)) state <= WR_RESP;
                end
                WR_RESP: begin
                    if (b_hs) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        rr_ptr  <= ptr_next;
                        state   <= IDLE;
                    end
                end
                RD: begin
                    if (ar_hs) state <= RD_RESP;
                end
                RD_RESP: begin
                    if (r_hs) begin
                        rr_ptr <= ptr_next;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_awaddr  = '0;
        m_awprot  = '0;
        m_awvalid = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_araddr  = '0;
        m_arprot  = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_arready = '0;
        s_rvalid  = '0;
        s_bresp   = '0;
        s_rdata   = '0;
        s_rresp   = '0;

        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            s_bresp[i*2 +: 2]           = m_bresp;
            s_rresp[i*2 +: 2]           = m_rresp;
            s_rdata[i*DATA_W +: DATA_W] = m_rdata;
        end

        if (state != IDLE) begin
            m_awaddr = s_awaddr[grant*ADDR_W +: ADDR_W];
            m_awprot = s_awprot[grant*3 +: 3];
            m_wdata  = s_wdata[grant*DATA_W +: DATA_W];
            m_wstrb  = s_wstrb[grant*STRB_W +: STRB_W];
            m_araddr = s_araddr[grant*ADDR_W +: ADDR_W];
            m_arprot = s_arprot[grant*3 +: 3];
        end

        case (state)
            WR: begin
                m_awvalid        = s_awvalid[grant] & ~aw_done;
                m_wvalid         = s_wvalid[grant]  & ~w_done;
                s_awready[grant] = m_awready & ~aw_done;
                s_wready[grant]  = m_wready  & ~w_done;
            end
            WR_RESP: begin
                m_bready        = s_bready[grant];
                s_bvalid[grant] = m_bvalid;
            end
            RD: begin
                m_arvalid        = s_arvalid[grant];
                s_arready[grant] = m_arready;
            end
            RD_RESP: begin
                m_rready        = s_rready[grant];
                s_rvalid[grant] = m_rvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axilite_arbiter.sv
// Directed bench for axilite_arbiter with a register-file slave and a
// transaction-level ownership model checked on every falling edge.
module tb_axilite_arbiter;
    import axilite_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N*AW-1:0] s_awaddr, s_araddr;
    logic [N*3-1:0]  s_awprot, s_arprot;
    logic [N-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N*DW-1:0] s_wdata, s_rdata;
    logic [N*SW-1:0] s_wstrb;
    logic [N*2-1:0]  s_bresp, s_rresp;

    logic [AW-1:0] m_awaddr, m_araddr;
    logic [2:0]    m_awprot, m_arprot;
    logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic          m_arvalid, m_arready, m_rvalid, m_rready;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_wstrb;
    logic [1:0]    m_bresp, m_rresp;

    axilite_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STRB_W    (SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ---------------- shared slave: 64-word register file ----------------
    logic aw_rdy_en = 1'b1, w_rdy_en = 1'b1, ar_rdy_en = 1'b1, b_hold = 1'b0;
    assign m_awready = aw_rdy_en;
    assign m_wready  = w_rdy_en;
    assign m_arready = ar_rdy_en;

    logic [31:0]   mem [0:63];
    logic          have_aw, have_w;
    logic [AW-1:0] sl_awaddr;
    logic [DW-1:0] sl_wdata;
    logic [SW-1:0] sl_wstrb;
    int aw_beats = 0, w_beats = 0, b_beats = 0, aw_hs_cyc = 0, w_hs_cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_aw <= 1'b0; have_w <= 1'b0;
            m_bvalid <= 1'b0; m_rvalid <= 1'b0;
            m_bresp <= RESP_OKAY; m_rresp <= RESP_OKAY; m_rdata <= '0;
        end else begin
            if (m_awvalid && m_awready) begin
                have_aw <= 1'b1; sl_awaddr <= m_awaddr;
                aw_beats <= aw_beats + 1; aw_hs_cyc <= cyc;
            end
            if (m_wvalid && m_wready) begin
                have_w <= 1'b1; sl_wdata <= m_wdata; sl_wstrb <= m_wstrb;
                w_beats <= w_beats + 1; w_hs_cyc <= cyc;
            end
            if (have_aw && have_w && !m_bvalid && !b_hold) begin
                for (int b = 0; b < SW; b++)
                    if (sl_wstrb[b]) mem[sl_awaddr[7:2]][8*b +: 8] <= sl_wdata[8*b +: 8];
                m_bvalid <= 1'b1; m_bresp <= RESP_OKAY;
                have_aw <= 1'b0; have_w <= 1'b0;
            end
            if (m_bvalid && m_bready) begin
                m_bvalid <= 1'b0; b_beats <= b_beats + 1;
            end
            if (m_arvalid && m_arready) begin
                m_rvalid <= 1'b1;
                if (m_araddr[9]) begin
                    m_rdata <= 32'hBAD0BAD0; m_rresp <= RESP_SLVERR;
                end else begin
                    m_rdata <= mem[m_araddr[7:2]]; m_rresp <= RESP_OKAY;
                end
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
        end
    end

    // ---------------- ownership model + per-cycle compare ----------------
    bit   md_busy = 0, md_write = 0, md_aw = 0, md_w = 0, md_ar = 0, prev_arv = 0;
    int   md_owner = 0, md_ptr = 0;
    int   done_q[$];
    int   b_hs_cyc = 0, ar_rise_cyc = 0;
    logic [14:0] quiet_vec;
    assign quiet_vec = {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};

    always @(negedge clk) begin
        if (!rst_n) begin
            md_busy = 0; md_ptr = 0; prev_arv = 0;
        end else begin
            int o;
            logic [N-1:0] req;
            bit found;
            o = md_owner;
            for (int i = 0; i < N; i++) begin
                chk("bresp_repl", s_bresp[i*2 +: 2], m_bresp);
                chk("rresp_repl", s_rresp[i*2 +: 2], m_rresp);
                chk("rdata_repl", s_rdata[i*DW +: DW], m_rdata);
            end
            if (!md_busy) begin
                chk("idle_quiet", quiet_vec, 0);
            end else begin
                for (int i = 0; i < N; i++)
                    if (i != o)
                        chk("ungranted_quiet", {s_awready[i], s_wready[i], s_bvalid[i], s_arready[i], s_rvalid[i]}, 0);
                if (md_write) begin
                    chk("wr_no_rd", {m_arvalid, m_rready, s_arready[o], s_rvalid[o]}, 0);
                    chk("m_awvalid", m_awvalid, s_awvalid[o] && !md_aw);
                    chk("m_wvalid", m_wvalid, s_wvalid[o] && !md_w);
                    chk("s_awready", s_awready[o], m_awready && !md_aw);
                    chk("s_wready", s_wready[o], m_wready && !md_w);
                    if (md_aw && md_w) begin
                        chk("m_bready", m_bready, s_bready[o]);
                        chk("s_bvalid", s_bvalid[o], m_bvalid);
                    end else begin
                        chk("bready_early", {m_bready, s_bvalid[o]}, 0);
                    end
                    if (m_awvalid) begin
                        chk("awaddr", m_awaddr, s_awaddr[o*AW +: AW]);
                        chk("awprot", m_awprot, s_awprot[o*3 +: 3]);
                    end
                    if (m_wvalid) begin
                        chk("wdata", m_wdata, s_wdata[o*DW +: DW]);
                        chk("wstrb", m_wstrb, s_wstrb[o*SW +: SW]);
                    end
                end else begin
                    chk("rd_no_wr", {m_awvalid, m_wvalid, m_bready, s_awready[o], s_wready[o], s_bvalid[o]}, 0);
                    chk("m_arvalid", m_arvalid, s_arvalid[o] && !md_ar);
                    chk("s_arready", s_arready[o], m_arready && !md_ar);
                    if (md_ar) begin
                        chk("m_rready", m_rready, s_rready[o]);
                        chk("s_rvalid", s_rvalid[o], m_rvalid);
                    end else begin
                        chk("rready_early", {m_rready, s_rvalid[o]}, 0);
                    end
                    if (m_arvalid) begin
                        chk("araddr", m_araddr, s_araddr[o*AW +: AW]);
                        chk("arprot", m_arprot, s_arprot[o*3 +: 3]);
                    end
                end
            end

            for (int i = 0; i < N; i++) begin
                if (s_bvalid[i] && s_bready[i]) begin done_q.push_back(i); b_hs_cyc = cyc; end
                if (s_rvalid[i] && s_rready[i]) done_q.push_back(i);
            end
            if (m_arvalid && !prev_arv) ar_rise_cyc = cyc;
            prev_arv = m_arvalid;

            // advance the model to what must hold after the coming edge
            if (!md_busy) begin
                req = s_awvalid | s_arvalid;
                found = 0;
                for (int k = 0; k < N; k++)
                    if (!found && req[(md_ptr + k) % N]) begin
                        found = 1; md_owner = (md_ptr + k) % N;
                    end
                if (found) begin
                    md_busy = 1; md_write = s_awvalid[md_owner];
                    md_aw = 0; md_w = 0; md_ar = 0;
                end
            end else begin
                if (s_awvalid[o] && s_awready[o]) md_aw = 1;
                if (s_wvalid[o] && s_wready[o])   md_w  = 1;
                if (s_arvalid[o] && s_arready[o]) md_ar = 1;
                if ((md_write && s_bvalid[o] && s_bready[o]) || (!md_write && s_rvalid[o] && s_rready[o])) begin
                    md_busy = 0; md_ptr = (o + 1) % N;
                end
            end
        end
    end

    // ---------------- master-side transaction tasks ----------------
    task automatic wr(input int m, input logic [15:0] a, input logic [31:0] d, input logic [3:0] st,
                      output logic [1:0] resp, output bit ok);
        bit ag, wg, a_hs, w_hs, got_b;
        int n;
        @(posedge clk); #1;
        s_awaddr[m*AW +: AW] = a; s_awprot[m*3 +: 3] = 3'(m + 1);
        s_wdata[m*DW +: DW] = d;  s_wstrb[m*SW +: SW] = st;
        s_awvalid[m] = 1'b1; s_wvalid[m] = 1'b1;
        ag = 0; wg = 0; got_b = 0; n = 0; ok = 0; resp = 2'b11;
        while (!(ag && wg) && n < 100 && rst_n) begin
            @(negedge clk);
            a_hs = s_awvalid[m] & s_awready[m];
            w_hs = s_wvalid[m] & s_wready[m];
            @(posedge clk); #1;
            if (a_hs) begin s_awvalid[m] = 1'b0; ag = 1; end
            if (w_hs) begin s_wvalid[m] = 1'b0; wg = 1; end
            n++;
        end
        n = 0;
        while (ag && wg && !got_b && n < 100 && rst_n) begin
            @(negedge clk);
            if (s_bvalid[m]) begin
                resp = s_bresp[m*2 +: 2]; got_b = 1;
                @(posedge clk); #1;
            end
            n++;
        end
        s_awvalid[m] = 1'b0; s_wvalid[m] = 1'b0;
        ok = got_b;
    endtask

    task automatic rd(input int m, input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp,
                      output int setc, output bit ok);
        bit ag, got_r, a_hs;
        int n;
        @(posedge clk); #1;
        s_araddr[m*AW +: AW] = a; s_arprot[m*3 +: 3] = 3'(m + 4);
        s_arvalid[m] = 1'b1; setc = cyc;
        ag = 0; got_r = 0; n = 0; d = '0; resp = 2'b11;
        while (!ag && n < 100 && rst_n) begin
            @(negedge clk);
            a_hs = s_arvalid[m] & s_arready[m];
            @(posedge clk); #1;
            if (a_hs) begin s_arvalid[m] = 1'b0; ag = 1; end
            n++;
        end
        n = 0;
        while (ag && !got_r && n < 100 && rst_n) begin
            @(negedge clk);
            if (s_rvalid[m]) begin
                d = s_rdata[m*DW +: DW]; resp = s_rresp[m*2 +: 2]; got_r = 1;
                @(posedge clk); #1;
            end
            n++;
        end
        s_arvalid[m] = 1'b0;
        ok = got_r;
    endtask

    function automatic int q_at(input int k);
        return (done_q.size() > k) ? done_q[k] : -1;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0]  r0, r1;
        logic [31:0] d0, d1;
        bit          ok0, ok1;
        int          sc0, sc1, aw0, w0, b0, n;

        s_awaddr = '0; s_awprot = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0; s_wvalid = '0;
        s_araddr = '0; s_arprot = '0; s_arvalid = '0;
        s_bready = '1; s_rready = '1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", quiet_vec, 0);
        @(negedge clk) rst_n = 1'b1;

        // single write from M0
        aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
        wr(0, 16'h0010, 32'hDEADBEEF, 4'hF, r0, ok0);
        chk("wr1_done", ok0, 1);
        chk("wr1_bresp", r0, RESP_OKAY);
        chk("wr1_aw_beats", aw_beats - aw0, 1);
        chk("wr1_w_beats", w_beats - w0, 1);
        chk("wr1_b_beats", b_beats - b0, 1);

        // read-back from M1, one arbitration cycle before m_arvalid
        rd(1, 16'h0010, d1, r1, sc1, ok1);
        chk("rd1_done", ok1, 1);
        chk("rd1_rdata", d1, 32'hDEADBEEF);
        chk("rd1_rresp", r1, RESP_OKAY);
        chk("rd1_idle_cycles", ar_rise_cyc - sc1, 1);

        // contention with pointer at M0
        done_q.delete();
        fork
            wr(0, 16'h0020, 32'h00000A0A, 4'hF, r0, ok0);
            wr(1, 16'h0024, 32'h00000B0B, 4'hF, r1, ok1);
        join
        chk("pair1_done", {ok0, ok1}, 2'b11);
        chk("pair1_first", q_at(0), 0);
        chk("pair1_second", q_at(1), 1);

        // move the pointer to M1, then contend again
        wr(0, 16'h0028, 32'h00000C0C, 4'hF, r0, ok0);
        done_q.delete();
        fork
            wr(0, 16'h002C, 32'h00000D0D, 4'h3, r0, ok0);
            wr(1, 16'h0030, 32'h00000E0E, 4'hC, r1, ok1);
        join
        chk("pair2_done", {ok0, ok1}, 2'b11);
        chk("pair2_first", q_at(0), 1);
        chk("pair2_second", q_at(1), 0);

        // same master offers AW and AR together: write completes first
        fork
            wr(0, 16'h0040, 32'h12345678, 4'hF, r0, ok0);
            rd(0, 16'h0040, d0, r1, sc0, ok1);
        join
        chk("wthr_done", {ok0, ok1}, 2'b11);
        chk("wthr_ar_after_b", ar_rise_cyc - b_hs_cyc, 2);
        chk("wthr_rdata", d0, 32'h12345678);

        // slave error passes through untouched
        rd(0, 16'h0200, d0, r0, sc0, ok0);
        chk("slverr_done", ok0, 1);
        chk("slverr_rresp", r0, RESP_SLVERR);
        chk("slverr_rdata", d0, 32'hBAD0BAD0);

        // W accepted before AW on M0
        aw_rdy_en = 1'b0;
        aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
        fork
            wr(0, 16'h0034, 32'hCAFEF00D, 4'hF, r0, ok0);
            begin repeat (5) @(posedge clk); #1 aw_rdy_en = 1'b1; end
        join
        chk("wfirst_done", ok0, 1);
        chk("wfirst_bresp", r0, RESP_OKAY);
        chk("wfirst_aw_beats", aw_beats - aw0, 1);
        chk("wfirst_w_beats", w_beats - w0, 1);
        chk("wfirst_b_beats", b_beats - b0, 1);
        chk("wfirst_order", w_hs_cyc < aw_hs_cyc, 1);

        // reset while M1 waits in the write-response phase
        b_hold = 1'b1;
        fork
            wr(1, 16'h0038, 32'h55555555, 4'hF, r1, ok1);
            begin
                n = 0;
                while (!(have_aw && have_w) && n < 50) begin @(negedge clk); n++; end
                chk("rst_reached_resp", have_aw && have_w, 1);
                #2 rst_n = 1'b0;
                #1 chk("rst_midop_quiet", quiet_vec, 0);
            end
        join
        b_hold = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // pointer must be back at M0: simultaneous reads serve M0 then M1
        done_q.delete();
        fork
            rd(0, 16'h0010, d0, r0, sc0, ok0);
            rd(1, 16'h0034, d1, r1, sc1, ok1);
        join
        chk("post_rst_done", {ok0, ok1}, 2'b11);
        chk("post_rst_first", q_at(0), 0);
        chk("post_rst_second", q_at(1), 1);
        chk("post_rst_m0_rdata", d0, 32'hDEADBEEF);
        chk("post_rst_m1_rdata", d1, 32'hCAFEF00D);
        chk("post_rst_m1_rresp", r1, RESP_OKAY);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
